// File: rtl/gcd_pkg.sv
// Shared types for the GCD job sequencer: data width default, FSM state encoding, job record.
package gcd_pkg;

  localparam int GCD_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4,
    ST_ACK    = 3'd5
  } gcd_state_t;

  typedef struct packed {
    logic [GCD_DATA_W-1:0] a;
    logic [GCD_DATA_W-1:0] b;
  } gcd_job_t;

endpackage

// File: rtl/gcd_job_sequencer_if.sv
// Job, core and result channels of gcd_job_sequencer.
// Res_Timeout exists only when GCD_SEQ_TIMEOUT_EN is defined.
interface gcd_job_sequencer_if #(
  parameter int DATA_W = gcd_pkg::GCD_DATA_W
);
  import gcd_pkg::*;

  // valid/ready: a transfer happens on a rising Clk edge where valid, ready and SCEN
  // are all high; the producer holds valid and its payload steady until then.
  logic              In_Valid;
  logic              In_Ready;
  logic [DATA_W-1:0] In_A;
  logic [DATA_W-1:0] In_B;

  logic              Start;
  logic              Ack;
  logic [DATA_W-1:0] Ain;
  logic [DATA_W-1:0] Bin;
  logic              q_I;
  logic              q_Done;
  logic [DATA_W-1:0] AB_GCD;

  logic              Res_Valid;
  logic              Res_Ready;
  logic [DATA_W-1:0] Res_A;
  logic [DATA_W-1:0] Res_B;
  logic [DATA_W-1:0] Res_GCD;
  logic              Res_Zero;
`ifdef GCD_SEQ_TIMEOUT_EN
  logic              Res_Timeout;
`endif
  logic [7:0]        Job_Count;
  gcd_state_t        dbg_state;

  modport master (
    input  In_Valid, In_A, In_B, q_I, q_Done, AB_GCD, Res_Ready,
    output In_Ready, Start, Ack, Ain, Bin, Res_Valid, Res_A, Res_B, Res_GCD, Res_Zero,
`ifdef GCD_SEQ_TIMEOUT_EN
    Res_Timeout,
`endif
    Job_Count, dbg_state
  );

  modport slave (
    output In_Valid, In_A, In_B, q_I, q_Done, AB_GCD, Res_Ready,
    input  In_Ready, Start, Ack, Ain, Bin, Res_Valid, Res_A, Res_B, Res_GCD, Res_Zero,
`ifdef GCD_SEQ_TIMEOUT_EN
    Res_Timeout,
`endif
    Job_Count, dbg_state
  );

endinterface

// File: rtl/gcd_job_fifo.sv
// Job FIFO for the GCD sequencer: DEPTH entries of WIDTH bits, extra pointer bit for full/empty.
module gcd_job_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = en && push && !full;
  assign do_pop  = en && pop && !empty;

  // Flags derive only from registered pointers, so a pop never makes room in the same cycle.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/gcd_job_sequencer.sv
// Feeds buffered (A,B) jobs to the GCD core over Start/Ack/q_Done and collects results.
// Optional watchdog in WAIT with Res_Timeout output: define GCD_SEQ_TIMEOUT_EN.
module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int DATA_W      = GCD_DATA_W,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                SCEN,
  gcd_job_sequencer_if.master bus
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("gcd_job_sequencer: DEPTH must be a power of two >= 2, TIMEOUT_CYC >= 1");
  end

  gcd_state_t          state;
  logic                start_q;
  logic                ack_q;
  logic                res_valid_q;
  logic                res_zero_q;
  logic [DATA_W-1:0]   ain_q;
  logic [DATA_W-1:0]   bin_q;
  logic [DATA_W-1:0]   res_a_q;
  logic [DATA_W-1:0]   res_b_q;
  logic [DATA_W-1:0]   res_gcd_q;
  logic [7:0]          job_count_q;
  logic [2*DATA_W-1:0] fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [DATA_W-1:0]   head_a;
  logic [DATA_W-1:0]   head_b;

`ifdef GCD_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wdog;
  logic            res_timeout_q;
  assign bus.Res_Timeout = res_timeout_q;
`endif

  assign push   = bus.In_Valid && !fifo_full;
  assign pop    = (state == ST_IDLE) && !fifo_empty;
  assign head_a = fifo_dout[2*DATA_W-1:DATA_W];
  assign head_b = fifo_dout[DATA_W-1:0];

  gcd_job_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst_n (Reset_n),
    .en    (SCEN),
    .push  (push),
    .pop   (pop),
    .din   ({bus.In_A, bus.In_B}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_IDLE;
      start_q     <= 1'b0;
      ack_q       <= 1'b0;
      ain_q       <= '0;
      bin_q       <= '0;
      res_valid_q <= 1'b0;
      res_a_q     <= '0;
      res_b_q     <= '0;
      res_gcd_q   <= '0;
      res_zero_q  <= 1'b0;
      job_count_q <= '0;
`ifdef GCD_SEQ_TIMEOUT_EN
      wdog          <= '0;
      res_timeout_q <= 1'b0;
`endif
    end else if (SCEN) begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            ain_q   <= head_a;
            bin_q   <= head_b;
            res_a_q <= head_a;
            res_b_q <= head_b;
            // A zero operand never reaches the core; report it directly.
            if (head_a == '0 || head_b == '0) begin
              res_gcd_q   <= '0;
              res_zero_q  <= 1'b1;
              res_valid_q <= 1'b1;
`ifdef GCD_SEQ_TIMEOUT_EN
              res_timeout_q <= 1'b0;
`endif
              state <= ST_RESULT;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (bus.q_I) begin
            start_q <= 1'b1;
            state   <= ST_START;
          end
        end
        ST_START: begin
          start_q <= 1'b0;
`ifdef GCD_SEQ_TIMEOUT_EN
          wdog    <= '0;
`endif
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.q_Done) begin
            res_gcd_q   <= bus.AB_GCD;
            res_zero_q  <= 1'b0;
            res_valid_q <= 1'b1;
`ifdef GCD_SEQ_TIMEOUT_EN
            res_timeout_q <= 1'b0;
`endif
            state <= ST_RESULT;
          end
`ifdef GCD_SEQ_TIMEOUT_EN
          else if (wdog == WD_W'(TIMEOUT_CYC - 1)) begin
            res_gcd_q     <= '0;
            res_zero_q    <= 1'b0;
            res_valid_q   <= 1'b1;
            res_timeout_q <= 1'b1;
            state         <= ST_RESULT;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
        ST_RESULT: begin
          if (bus.Res_Ready) begin
            res_valid_q <= 1'b0;
            job_count_q <= job_count_q + 8'd1;
            if (res_zero_q) begin
              state <= ST_IDLE;
            end else begin
              ack_q <= 1'b1;
              state <= ST_ACK;
            end
          end
        end
        ST_ACK: begin
          ack_q <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.In_Ready  = !fifo_full;
  assign bus.Start     = start_q;
  assign bus.Ack       = ack_q;
  assign bus.Ain       = ain_q;
  assign bus.Bin       = bin_q;
  assign bus.Res_Valid = res_valid_q;
  assign bus.Res_A     = res_a_q;
  assign bus.Res_B     = res_b_q;
  assign bus.Res_GCD   = res_gcd_q;
  assign bus.Res_Zero  = res_zero_q;
  assign bus.Job_Count = job_count_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Bench for gcd_job_sequencer: subtractive GCD core model, randomized jobs, queue-based scoreboard.
module tb_gcd_job_sequencer;
  import gcd_pkg::*;

  localparam int W     = GCD_DATA_W;
  localparam int EXP_W = 3 * W + 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         scen      = 1'b1;
  logic         in_valid  = 1'b0;
  logic [W-1:0] in_a      = '0;
  logic [W-1:0] in_b      = '0;
  logic         res_ready = 1'b1;
  int           scen_mode = 0;
  int           rr_mode   = 0;

  int checks = 0;
  int errors = 0;

  logic [EXP_W-1:0] exp_q[$];
  int exp_job_count = 0;
  int exp_nonzero   = 0;
  int start_cnt     = 0;
  int ack_cnt       = 0;

  gcd_job_sequencer_if #(.DATA_W(W)) bus ();

  gcd_job_sequencer #(
    .DATA_W      (W),
    .DEPTH       (4),
    .TIMEOUT_CYC (1023)
  ) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .SCEN    (scen),
    .bus     (bus)
  );

  assign bus.In_Valid  = in_valid;
  assign bus.In_A      = in_a;
  assign bus.In_B      = in_b;
  assign bus.Res_Ready = res_ready;

  // ---------------- GCD core model (one subtraction per enabled cycle) ----------------
  logic [1:0]   cst;
  logic [W-1:0] ca, cb, ca0, cb0, c_gcd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cst <= 2'd0; ca <= '0; cb <= '0; ca0 <= '0; cb0 <= '0; c_gcd <= '0;
    end else if (scen) begin
      case (cst)
        2'd0: if (bus.Start) begin
          ca <= bus.Ain; cb <= bus.Bin; ca0 <= bus.Ain; cb0 <= bus.Bin; cst <= 2'd1;
        end
        2'd1: begin
          if (ca == cb) begin c_gcd <= ca; cst <= 2'd2; end
          else if (ca > cb) ca <= ca - cb;
          else cb <= cb - ca;
        end
        default: if (bus.Ack) cst <= 2'd0;
      endcase
    end
  end

  assign bus.q_I    = (cst == 2'd0);
  assign bus.q_Done = (cst == 2'd2);
  assign bus.AB_GCD = c_gcd;

  // ---------------- reference model & helpers ----------------
  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y, t;
    if (a == 0 || b == 0) return '0;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return W'(x);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- drivers ----------------
  initial forever begin
    @(posedge clk); #1;
    scen      = (scen_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    res_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic push_job(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    logic z;
    in_valid = 1'b1; in_a = a; in_b = b;
    forever begin
      @(negedge clk);
      if (bus.In_Ready && scen) break;
      if (++n > 4000) begin bound_expired("push_accept"); break; end
    end
    z = (a == 0) || (b == 0);
    exp_q.push_back({a, b, gcd_ref(a, b), z});
    if (!z) exp_nonzero++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain_and_totals(input string tag);
    int n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.dbg_state == ST_IDLE) break;
      if (++n > 30000) begin bound_expired({tag, "_drain"}); break; end
    end
    check({tag, "_start_pulses"}, start_cnt, exp_nonzero);
    check({tag, "_ack_pulses"}, ack_cnt, exp_nonzero);
    check({tag, "_job_count"}, bus.Job_Count, 8'(exp_job_count));
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, bus.In_Ready, 1);
    check({tag, "_start"}, bus.Start, 0);
    check({tag, "_ack"}, bus.Ack, 0);
    check({tag, "_ain_bin"}, {bus.Ain, bus.Bin}, 0);
    check({tag, "_res_valid"}, bus.Res_Valid, 0);
    check({tag, "_res_data"}, {bus.Res_A, bus.Res_B, bus.Res_GCD, bus.Res_Zero}, 0);
    check({tag, "_job_count"}, bus.Job_Count, 0);
    check({tag, "_state"}, bus.dbg_state, ST_IDLE);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [63:0]      snap_now, snap_prev;
  logic             scen_prev = 1'b1;
  logic             have_snap = 1'b0;
  logic [EXP_W-1:0] exp_item;

  always @(negedge clk) begin
    if (!rst_n) begin
      have_snap = 1'b0;
    end else begin
      if (scen && bus.Start) begin start_cnt++; check("start_core_idle", cst, 0); end
      if (scen && bus.Ack)   begin ack_cnt++;   check("ack_core_done", cst, 2); end
      if (cst != 2'd0) check("ain_bin_stable", {bus.Ain, bus.Bin}, {ca0, cb0});

      if (scen && bus.Res_Valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: actual A=%0d B=%0d required none", bus.Res_A, bus.Res_B);
        end else begin
          exp_item = exp_q.pop_front();
          check("res_a", bus.Res_A, exp_item[EXP_W-1 -: W]);
          check("res_b", bus.Res_B, exp_item[2*W : W+1]);
          check("res_gcd", bus.Res_GCD, exp_item[W:1]);
          check("res_zero", bus.Res_Zero, exp_item[0]);
          check("job_count_at_accept", bus.Job_Count, 8'(exp_job_count));
          exp_job_count++;
        end
      end

      snap_now = {8'd0, bus.In_Ready, bus.Start, bus.Ack, bus.Ain, bus.Bin, bus.Res_Valid,
                  bus.Res_A, bus.Res_B, bus.Res_GCD, bus.Res_Zero, bus.Job_Count, bus.dbg_state};
      if (have_snap && !scen_prev) check("scen_freeze", snap_now, snap_prev);
      snap_prev = snap_now;
      scen_prev = scen;
      have_snap = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  gcd_job_t seq3[3];
  gcd_job_t hold5[5];

  initial begin
    int ack_base;
    int n;
    logic [W-1:0] ra, rb;

    seq3[0] = '{a: 8'd5,  b: 8'd15};
    seq3[1] = '{a: 8'd36, b: 8'd24};
    seq3[2] = '{a: 8'd7,  b: 8'd13};
    hold5[0] = '{a: 8'd48,  b: 8'd18};
    hold5[1] = '{a: 8'd21,  b: 8'd14};
    hold5[2] = '{a: 8'd100, b: 8'd75};
    hold5[3] = '{a: 8'd17,  b: 8'd5};
    hold5[4] = '{a: 8'd64,  b: 8'd48};

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    wait_cycles(1);

    // single job
    push_job(8'd36, 8'd24);
    drain_and_totals("single");

    // back-to-back jobs
    for (int i = 0; i < 3; i++) push_job(seq3[i].a, seq3[i].b);
    drain_and_totals("b2b");

    // consumer stalls: FIFO fills, result held, no Ack
    rr_mode  = 1;
    wait_cycles(1);
    ack_base = ack_cnt;
    for (int i = 0; i < 5; i++) push_job(hold5[i].a, hold5[i].b);
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.Res_Valid) break;
      if (++n > 2000) begin bound_expired("hold_res_valid"); break; end
    end
    repeat (3) @(negedge clk);
    check("hold_in_ready_low", bus.In_Ready, 0);
    check("hold_res_valid", bus.Res_Valid, 1);
    check("hold_no_ack", {bus.Ack, 24'(ack_cnt)}, {1'b0, 24'(ack_base)});
    @(posedge clk); #1;
    rr_mode = 0;
    drain_and_totals("hold");

    // zero operand bypasses core
    push_job(8'd0, 8'd9);
    push_job(8'd9, 8'd6);
    drain_and_totals("zero");

    // reset during WAIT
    push_job(8'd36, 8'd24);
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.dbg_state == ST_WAIT) break;
      if (++n > 200) begin bound_expired("reach_wait"); break; end
    end
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    exp_job_count = 0; exp_nonzero = 0; start_cnt = 0; ack_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cycles(1);
    push_job(8'd12, 8'd18);
    drain_and_totals("post_reset");

    // gated clock enable
    scen_mode = 1;
    push_job(8'd36, 8'd24);
    drain_and_totals("scen");

    // randomized jobs, random enable and consumer backpressure
    rr_mode = 2;
    for (int i = 0; i < 16; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
      push_job(ra, rb);
      if ($urandom_range(0, 2) == 0) wait_cycles($urandom_range(1, 20));
    end
    rr_mode = 0;
    drain_and_totals("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
